// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Shows an 8-bit unsigned value in decimal on a 4-digit,
//            multiplexed, common-anode 7-segment display. Values are loaded
//            over a valid/ready handshake and converted to BCD sequentially
//            (shift-add-3, one bit per cycle). A free-running refresh divider
//            scans the digits independently of the converter.
// Ports    : clk      - system clock, rising edge
//            rst_n    - asynchronous active-low reset
//            in_valid - upstream presents a value on in_data
//            in_data  - unsigned value 0..255
//            in_ready - block can accept a value this cycle
//            done     - one-cycle pulse when a new value reaches the display
//            D        - segments, active-low {dp,g,f,e,d,c,b,a}, dp always off
//            AN       - digit anodes, active-low, AN[0] = ones digit
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_LZ    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       done,
  output logic [7:0] D,
  output logic [3:0] AN
);

  localparam int              c_div_w    = $clog2(REFRESH_DIV);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(REFRESH_DIV - 1);

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_conv = 1'b1;

  // Converter state
  logic [0:0]  r_state;
  logic [7:0]  r_bin;
  logic [11:0] r_bcd;
  logic [2:0]  r_cnt;
  logic        r_ready;
  logic        r_done;

  // Committed display value
  logic [3:0]  r_hund;
  logic [3:0]  r_tens;
  logic [3:0]  r_ones;

  // Scan engine
  logic [c_div_w-1:0] r_div;
  logic [1:0]         r_idx;
  logic [3:0]         r_an;
  logic [7:0]         r_d;

  logic [11:0] w_adj;
  logic [12:0] w_next_bcd;
  logic [7:0]  w_next_bin;
  logic        w_tick;
  logic [3:0]  w_nib;
  logic        w_blank;
  logic [6:0]  w_seg;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Shift-add-3 step: correct every nibble >= 5 before shifting so the
  // shift produces a valid BCD digit.
  always_comb begin
    w_adj = r_bcd;
    for (int n = 0; n < 3; n++) begin
      if (r_bcd[4*n +: 4] >= 4'd5) begin
        w_adj[4*n +: 4] = r_bcd[4*n +: 4] + 4'd3;
      end
    end
    w_next_bcd = {w_adj, r_bin[7]};
    w_next_bin = {r_bin[6:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_hund  <= '0;
      r_tens  <= '0;
      r_ones  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (in_valid && r_ready) begin
            r_bin   <= in_data;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_state <= c_st_conv;
          end
        end
        c_st_conv: begin
          r_bin <= w_next_bin;
          r_bcd <= w_next_bcd[11:0];
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            // Bit 12 can only be set by a corrupted scratch value; force the
            // hundreds digit out of range so it displays blank.
            r_hund  <= w_next_bcd[12] ? 4'hF : w_next_bcd[11:8];
            r_tens  <= w_next_bcd[7:4];
            r_ones  <= w_next_bcd[3:0];
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign w_tick = (r_div == c_div_last);

  // Digit content for the slot about to be shown (r_idx).
  always_comb begin
    w_nib   = 4'd0;
    w_blank = 1'b0;
    case (r_idx)
      2'd0: w_nib = r_ones;
      2'd1: begin
        w_nib   = r_tens;
        w_blank = (BLANK_LZ != 0) && (r_hund == 4'd0) && (r_tens == 4'd0);
      end
      2'd2: begin
        w_nib   = r_hund;
        w_blank = (BLANK_LZ != 0) && (r_hund == 4'd0);
      end
      default: w_blank = 1'b1;
    endcase
    w_seg = w_blank ? 7'h7F : seg7(w_nib);
  end

  // r_idx names the digit the next tick will select, so the first tick
  // after reset lights digit 0. AN and D load on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_idx <= '0;
      r_an  <= 4'b1111;
      r_d   <= 8'hFF;
    end else if (w_tick) begin
      r_div <= '0;
      r_idx <= r_idx + 2'd1;
      r_an  <= ~(4'b0001 << r_idx);
      r_d   <= {1'b1, w_seg};
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign in_ready = r_ready;
  assign done     = r_done;
  assign D        = r_d;
  assign AN       = r_an;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Purpose  : Self-checking bench for seg7_scan_driver (REFRESH_DIV=4,
//            BLANK_LZ=1). A handshake model pushes accepted values into a
//            scoreboard queue; a monitor pops on each done pulse and checks
//            the scanned digits against a decimal reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam int DIV = 4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       done;
  logic [7:0] D;
  logic [3:0] AN;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int   k;
  int   busy;
  logic m_ready;
  logic m_done;
  int   exp_q[$];

  // Monitor state
  int         disp;
  logic [3:0] exp_an;
  logic [7:0] exp_d;

  seg7_scan_driver #(.REFRESH_DIV(DIV), .BLANK_LZ(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .done     (done),
    .D        (D),
    .AN       (AN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] seg_byte(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Display byte for digit j of value v: leading zeros blank, digit 3 blank.
  function automatic logic [7:0] dig_byte(input int v, input int j);
    int nd;
    int p;
    nd = (v >= 100) ? 3 : (v >= 10) ? 2 : 1;
    if (j >= nd) return 8'hFF;
    p = (j == 0) ? 1 : (j == 1) ? 10 : 100;
    return seg_byte((v / p) % 10);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Handshake model: one value per 9 cycles, result 8 edges after accept.
  initial begin
    k = 0; busy = 0; m_ready = 1'b1; m_done = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        k = 0; busy = 0; m_ready = 1'b1; m_done = 1'b0;
        exp_q.delete();
      end else begin
        logic acc;
        acc = in_valid && m_ready;
        k++;
        m_done = 1'b0;
        if (busy > 0) begin
          busy--;
          if (busy == 0) begin
            m_done  = 1'b1;
            m_ready = 1'b1;
          end
        end
        if (acc) begin
          busy    = 8;
          m_ready = 1'b0;
          exp_q.push_back(int'(in_data));
        end
      end
    end
  end

  // Monitor: checks handshake outputs and scanned digits every cycle.
  initial begin
    disp = 0; exp_an = 4'hF; exp_d = 8'hFF;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        disp = 0; exp_an = 4'hF; exp_d = 8'hFF;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_AN", int'(AN), 'hF);
        chk("rst_D", int'(D), 'hFF);
      end else begin
        chk("in_ready", int'(in_ready), int'(m_ready));
        chk("done", int'(done), int'(m_done));
        if (k > 0 && (k % DIV) == 0) begin
          int j;
          j = ((k / DIV) - 1) % 4;
          exp_an = ~(4'b0001 << j);
          exp_d  = dig_byte(disp, j);
        end
        chk("AN", int'(AN), int'(exp_an));
        chk("D", int'(D), int'(exp_d));
        if (done) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL commit: actual=done expected=no pending value at %0t", $time);
          end else begin
            disp = exp_q.pop_front();
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Wait (bounded) until the DUT shows ready with valid high, then pass the
  // accepting edge.
  task automatic wait_accept();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: actual=no ready expected=ready within 40 cycles");
    end
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] v);
    in_valid = 1'b1;
    in_data  = v;
    wait_accept();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(20);

    send(8'd237); idle(20);
    send(8'd5);   idle(20);
    send(8'd40);  idle(20);

    // Held valid: 7 must wait for the 255 conversion to finish.
    in_valid = 1'b1; in_data = 8'd255;
    wait_accept();
    in_data = 8'd7;
    wait_accept();
    in_valid = 1'b0;
    idle(24);

    // Reset during conversion of 200.
    send(8'd200);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(20);

    send(8'd0);   idle(20);
    send(8'd100); idle(20);

    repeat (25) begin
      send(8'($urandom_range(0, 255)));
      idle($urandom_range(0, 12));
    end
    idle(30);

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
